// File: rtl/mux4_scan_pkg.sv
// Shared definitions for the 4:1 mux scan sequencer: state encoding,
// channel geometry and the shadow-capture helper.
package mux4_scan_pkg;

    localparam int NCH   = 4;
    localparam int SEL_W = 2;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETTLE = 2'd1;
    localparam logic [1:0] ST_SAMPLE = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    typedef enum logic [1:0] {
        IDLE   = ST_IDLE,
        SETTLE = ST_SETTLE,
        SAMPLE = ST_SAMPLE,
        DONE   = ST_DONE
    } state_t;

    // Returns word with bit idx replaced by bit_val.
    function automatic logic [NCH-1:0] capture_bit(input logic [NCH-1:0] word,
                                                   input logic [SEL_W-1:0] idx,
                                                   input logic bit_val);
        logic [NCH-1:0] res;
        res      = word;
        res[idx] = bit_val;
        return res;
    endfunction

endpackage

// File: rtl/mux4_scan_ctrl_if.sv
// Bus between the scan sequencer and the mux/downstream side.
// start is a level request: it is taken on any edge where the sequencer is
// IDLE or DONE and ignored otherwise; done is a one-cycle strobe qualifying data_out.
interface mux4_scan_ctrl_if;

    logic                                  start;
    logic                                  dir;
    logic                                  mux_out;
    logic [mux4_scan_pkg::SEL_W-1:0]       sel;
    logic                                  busy;
    logic                                  done;
    logic [mux4_scan_pkg::NCH-1:0]         data_out;

    modport master (
        input  start, dir, mux_out,
        output sel, busy, done, data_out
    );

    modport slave (
        output start, dir, mux_out,
        input  sel, busy, done, data_out
    );

endinterface

// File: rtl/mux4_scan_ctrl_scan_counter.sv
// Dwell down-counter: load has priority over decrement, stops at zero.
module scan_counter
    import mux4_scan_pkg::*;
#(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic         dec,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/mux4_scan_ctrl.sv
// Steps a 4:1 mux through its channels, dwells DWELL cycles on each, samples
// mux_out and publishes the four samples as one word with a done strobe.
module mux4_scan_ctrl
    import mux4_scan_pkg::*;
#(
    parameter int DWELL = 1
) (
    input  logic               clk,
    input  logic               reset,
    mux4_scan_ctrl_if.master   bus,
    output state_t             state_dbg
);

    localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CW-1:0] RELOAD = CW'(DWELL - 1);

    state_t           state;
    logic             dir_q;
    logic [NCH-1:0]   shadow;
    logic [SEL_W-1:0] last_ch;
    logic             cnt_load;
    logic             cnt_dec;
    logic             cnt_zero;

    assign last_ch   = dir_q ? SEL_W'(NCH - 1) : '0;
    assign state_dbg = state;

    always_comb begin
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;
        case (state)
            IDLE, DONE: cnt_load = bus.start;
            SETTLE:     cnt_dec  = !cnt_zero;
            SAMPLE:     cnt_load = (bus.sel != last_ch);
            default:    ;
        endcase
    end

    scan_counter #(.W(CW)) u_dwell (
        .clk      (clk),
        .reset    (reset),
        .load     (cnt_load),
        .dec      (cnt_dec),
        .load_val (RELOAD),
        .zero     (cnt_zero)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            dir_q        <= 1'b0;
            shadow       <= '0;
            bus.sel      <= '0;
            bus.busy     <= 1'b0;
            bus.done     <= 1'b0;
            bus.data_out <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    bus.done <= 1'b0;
                    if (bus.start) begin
                        dir_q    <= bus.dir;
                        bus.sel  <= bus.dir ? '0 : SEL_W'(NCH - 1);
                        bus.busy <= 1'b1;
                        state    <= SETTLE;
                    end else begin
                        bus.busy <= 1'b0;
                        state    <= IDLE;
                    end
                end
                SETTLE: begin
                    if (cnt_zero) begin
                        state <= SAMPLE;
                    end
                end
                SAMPLE: begin
                    shadow <= capture_bit(shadow, bus.sel, bus.mux_out);
                    // The final edge publishes the word including the bit taken now.
                    if (bus.sel == last_ch) begin
                        bus.data_out <= capture_bit(shadow, bus.sel, bus.mux_out);
                        bus.busy     <= 1'b0;
                        bus.done     <= 1'b1;
                        state        <= DONE;
                    end else begin
                        bus.sel <= dir_q ? bus.sel + 2'd1 : bus.sel - 2'd1;
                        state   <= SETTLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
